// File: rtl/gpi_uart_rx_pkg.sv
// Shared types and constants for the GPI UART receiver.
// Frame length depends on the optional GPI_RX_PARITY_EN even-parity feature.
package gpi_uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DATA_BITS        = 8;
    localparam int CNT_W            = 10;
`ifdef GPI_RX_PARITY_EN
    localparam int FRAME_BITS       = 11;
`else
    localparam int FRAME_BITS       = 10;
`endif

    // Even parity holds when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        even_parity_ok = ~(^{data, par});
    endfunction

endpackage

// File: rtl/gpi_uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle (high) line shows no edge after reset.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Double-register the asynchronous input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/gpi_uart_rx.sv
// UART receiver (8N1, or 8E1 when GPI_RX_PARITY_EN is defined) feeding the CPU gpi port.
// gpi holds the last good byte; gpi_we strobes one cycle when it changes.
module gpi_uart_rx
    import gpi_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] gpi,
    output logic       gpi_we,
    output logic       frame_err
`ifdef GPI_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    rx_state_t        state_r, state_nx_s;
    logic             rxs_s, rxs_prev_r, fall_s, mid_s, full_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             bit_smp_s, stop_smp_s, good_s, par_ok_s;
`ifdef GPI_RX_PARITY_EN
    logic             par_smp_s, par_bit_r;
`endif

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (rxd),
        .q     (rxs_s)
    );

    assign fall_s = rxs_prev_r & ~rxs_s;
    assign mid_s  = (cnt_r == HALF_M1);
    assign full_s = (cnt_r == FULL_M1);
`ifdef GPI_RX_PARITY_EN
    assign par_ok_s = even_parity_ok(shift_r, par_bit_r);
`else
    assign par_ok_s = 1'b1;
`endif
    assign good_s = stop_smp_s & rxs_s & par_ok_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nx_s = START;
                else        state_nx_s = IDLE;
            end
            START: begin
                if (mid_s) state_nx_s = rxs_s ? IDLE : DATA;
                else       state_nx_s = START;
            end
            DATA: begin
`ifdef GPI_RX_PARITY_EN
                if (full_s && idx_r == 3'd7) state_nx_s = PARITY;
`else
                if (full_s && idx_r == 3'd7) state_nx_s = STOP;
`endif
                else                         state_nx_s = DATA;
            end
`ifdef GPI_RX_PARITY_EN
            PARITY: begin
                if (full_s) state_nx_s = STOP;
                else        state_nx_s = PARITY;
            end
`endif
            STOP: begin
                if (full_s) state_nx_s = IDLE;
                else        state_nx_s = STOP;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Bit-timing counter and sample-strobe decode.
    always_comb begin
        cnt_nx_s   = cnt_r + CNT_W'(1);
        bit_smp_s  = 1'b0;
        stop_smp_s = 1'b0;
`ifdef GPI_RX_PARITY_EN
        par_smp_s  = 1'b0;
`endif
        case (state_r)
            IDLE: cnt_nx_s = CNT_ZERO;
            START: begin
                if (mid_s) cnt_nx_s = CNT_ZERO;
                else       cnt_nx_s = cnt_r + CNT_W'(1);
            end
            DATA: begin
                if (full_s) begin
                    cnt_nx_s  = CNT_ZERO;
                    bit_smp_s = 1'b1;
                end else begin
                    bit_smp_s = 1'b0;
                end
            end
`ifdef GPI_RX_PARITY_EN
            PARITY: begin
                if (full_s) begin
                    cnt_nx_s  = CNT_ZERO;
                    par_smp_s = 1'b1;
                end else begin
                    par_smp_s = 1'b0;
                end
            end
`endif
            STOP: begin
                if (full_s) begin
                    cnt_nx_s   = CNT_ZERO;
                    stop_smp_s = 1'b1;
                end else begin
                    stop_smp_s = 1'b0;
                end
            end
            default: cnt_nx_s = CNT_ZERO;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxs_prev_r <= 1'b1;
            cnt_r      <= CNT_ZERO;
            idx_r      <= 3'd0;
            shift_r    <= 8'h00;
            gpi        <= 8'h00;
            gpi_we     <= 1'b0;
            frame_err  <= 1'b0;
`ifdef GPI_RX_PARITY_EN
            par_bit_r  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rxs_prev_r <= rxs_s;
            cnt_r      <= cnt_nx_s;
            gpi_we     <= good_s;
            if (state_r == START) idx_r <= 3'd0;
            else if (bit_smp_s)   idx_r <= idx_r + 3'd1;
            if (bit_smp_s)  shift_r   <= {rxs_s, shift_r[7:1]};
            if (good_s)     gpi       <= shift_r;
            if (stop_smp_s) frame_err <= ~rxs_s;
`ifdef GPI_RX_PARITY_EN
            if (par_smp_s)  par_bit_r  <= rxs_s;
            if (stop_smp_s) parity_err <= rxs_s & ~par_ok_s;
`endif
        end
    end

endmodule

// File: doc/gpi_uart_rx.md
GPI_UART_RX -- requirements
Module: gpi_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 4..1023).
REQ-002 SHALL have port clock, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rxd, input, 1, asynchronous serial line: idle high, 8N1 (8E1 with parity feature).
REQ-005 SHALL have port gpi, output, 8, last correctly received byte, held until the next good byte.
REQ-006 SHALL have port gpi_we, output, 1, one-cycle strobe marking a new value on gpi.
REQ-007 SHALL have port frame_err, output, 1, sticky: last frame had stop bit = 0.
REQ-008 SHALL have port parity_err, output, 1, sticky: last frame failed even parity; present only with GPI_RX_PARITY_EN.

Function
REQ-009 SHALL pass rxd through a two-flop synchronizer; all logic uses the synchronized value rxs.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (feature only), STOP.
REQ-011 IDLE: SHALL move to START on a falling edge of rxs; a line held low SHALL NOT retrigger.
REQ-012 START: at count CLKS_PER_BIT/2 - 1 SHALL resample rxs; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no outputs change).
REQ-013 DATA: SHALL sample rxs every CLKS_PER_BIT cycles, shifting LSB first; after bit 7 SHALL go to PARITY (feature) or STOP.
REQ-014 PARITY: SHALL sample one bit and require the XOR of 8 data bits and parity bit to be 0.
REQ-015 STOP: on a sample of 1 with parity ok, SHALL load gpi and pulse gpi_we for exactly one cycle, then clear frame_err and parity_err.
REQ-016 STOP: on a sample of 0, SHALL set frame_err, leave gpi unchanged, suppress gpi_we.
REQ-017 On a parity fail with stop = 1, SHALL set parity_err, leave gpi unchanged, suppress gpi_we.
REQ-018 After STOP SHALL return to IDLE in the same cycle as the stop sample; a new falling edge on the next cycle SHALL be accepted (back-to-back frames).
REQ-019 gpi_we SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after rxd first goes low (plus CLKS_PER_BIT with parity), +/-1 cycle.
REQ-020 The bit counter SHALL saturate at CLKS_PER_BIT-1 and wrap to 0 on each sample; the data bit index SHALL be 3 bits and SHALL never wrap mid-frame.
REQ-021 gpi_we SHALL never be asserted on two consecutive cycles.

Reset
REQ-022 On reset low, SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, gpi = 8'h00, gpi_we = 0, frame_err = 0, parity_err = 0.
REQ-023 A partially received frame SHALL be discarded on reset; the first frame after release SHALL require a fresh falling edge.

Configuration
REQ-024 Macro GPI_RX_PARITY_EN defined: SHALL add the PARITY state, the parity_err port and the even-parity check (frame = 11 bits).
REQ-025 Macro GPI_RX_PARITY_EN undefined: no PARITY state, no parity_err port; frame = 10 bits; all other behaviour identical.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, START, DATA, PARITY, STOP), the default CLKS_PER_BIT and frame-length constants.
REQ-027 The synchronizer SHALL be a separate sub-module named sync2 (clock, reset, d, q; reset value 1).
REQ-028 gpi and gpi_we SHALL connect directly to the CPU's gpi and gpi_we inputs with no extra glue.

Verification (CLKS_PER_BIT = 16)
REQ-029 Send 0xA5, stop = 1 -> gpi = 8'hA5, one gpi_we pulse 154 +/-1 cycles after the start edge, frame_err = 0.
REQ-030 rxd low for 4 cycles then high -> no gpi_we, state back in IDLE, gpi unchanged.
REQ-031 Send 0x3C with stop = 0 -> frame_err = 1, gpi keeps previous value, no gpi_we; next good 0x11 -> gpi = 8'h11, frame_err = 0.
REQ-032 Back-to-back 0x00 then 0xFF with no idle gap -> two gpi_we pulses 160 cycles apart, gpi = 8'h00 then 8'hFF.
REQ-033 Reset low at data bit 4 of 0x55, released, then send 0x7E -> no gpi_we for 0x55, gpi = 8'h7E afterwards.
REQ-034 With GPI_RX_PARITY_EN: 0x07 with parity 1 -> gpi = 8'h07; 0x07 with parity 0 -> parity_err = 1, no gpi_we.
